// File: rtl/inst_mem_responder_pkg.sv
// Shared bus widths, constants and FSM encodings for the instruction memory responder.
package inst_mem_responder_pkg;

    // Default bus widths (InstAddrBus / InstBus) and store depth.
    localparam int INST_ADDR_W     = 32;
    localparam int INST_DATA_W     = 32;
    localparam int INST_DEPTH_LOG2 = 10;

    // Chip-enable levels driven by the program counter.
    localparam logic CHIP_ENABLE  = 1'b1;
    localparam logic CHIP_DISABLE = 1'b0;

    localparam logic [INST_DATA_W-1:0] ZERO_WORD    = 32'h0000_0000;
    localparam logic [INST_DATA_W-1:0] DEF_NOP_WORD = 32'h0000_0000;

    // Responder FSM encodings.
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

endpackage

// File: rtl/inst_mem_array.sv
// Word-addressed synchronous instruction store: one write port, one registered read port.
// Kept separate so it can be replaced by a vendor block RAM.
module inst_mem_array #(
    parameter int DATA_W     = 32,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [DEPTH_LOG2-1:0] waddr_i,
    input  logic [DATA_W-1:0]     wdata_i,
    input  logic [DEPTH_LOG2-1:0] raddr_i,
    output logic [DATA_W-1:0]     rdata_o
);

    logic [DATA_W-1:0] mem [0:(1<<DEPTH_LOG2)-1];
    logic [DATA_W-1:0] rdata_q;

    // Write on we_i, read every cycle into a register (1-cycle latency, contents not reset).
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
        rdata_q <= mem[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/inst_mem_responder.sv
// Instruction-side memory responder: answers PC fetches with 1-cycle latency and
// accepts a streaming program load, freezing the pipeline while the load runs.
//
// Load port handshake: there is no ready. While the FSM is in LOAD every cycle with
// load_valid=1 writes load_data at the current write pointer; load_last marks the final
// word. load_start is a one-cycle pulse and (re)starts a load at word 0 from any state.
// Words offered outside LOAD (including after the store fills) are dropped.
module inst_mem_responder
    import inst_mem_responder_pkg::*;
#(
    parameter int                ADDR_W     = INST_ADDR_W,
    parameter int                DATA_W     = INST_DATA_W,
    parameter int                DEPTH_LOG2 = INST_DEPTH_LOG2,
    parameter logic [DATA_W-1:0] NOP_WORD   = DEF_NOP_WORD
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ce,
    input  logic [ADDR_W-1:0]     addr,
    output logic [DATA_W-1:0]     inst,
    output logic                  inst_valid,
    output logic                  addr_err,
    output logic                  stallreq,
    input  logic                  load_start,
    input  logic                  load_valid,
    input  logic [DATA_W-1:0]     load_data,
    input  logic                  load_last,
    output logic                  load_busy,
    output logic [DEPTH_LOG2:0]   load_count,
    output logic [1:0]            dbg_state
);

    localparam logic [DEPTH_LOG2-1:0] WPTR_ONE = 1;
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = 1;

    state_e                state_q, state_d;
    logic [DEPTH_LOG2-1:0] wptr_q, wptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  inst_valid_q, inst_valid_d;
    logic                  addr_err_q, addr_err_d;

    logic                  mem_we;
    logic [DATA_W-1:0]     mem_rdata;
    logic                  addr_in_range;

    // Full-width compare: any set bit above the store index is out of range.
    assign addr_in_range = (addr[ADDR_W-1:DEPTH_LOG2] == '0);

    inst_mem_array #(
        .DATA_W     (DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .clk     (clk),
        .we_i    (mem_we),
        .waddr_i (wptr_q),
        .wdata_i (load_data),
        .raddr_i (addr[DEPTH_LOG2-1:0]),
        .rdata_o (mem_rdata)
    );

    // Load FSM: next state, write pointer, word counter and store write strobe.
    always_comb begin
        state_d = state_q;
        wptr_d  = wptr_q;
        count_d = count_q;
        mem_we  = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (load_start) begin
                    state_d = ST_LOAD;
                    wptr_d  = '0;
                    count_d = '0;
                end
            end
            ST_LOAD: begin
                if (load_start) begin
                    wptr_d  = '0;
                    count_d = '0;
                end else if (load_valid) begin
                    mem_we  = 1'b1;
                    wptr_d  = wptr_q + WPTR_ONE;
                    count_d = count_q + CNT_ONE;
                    // Leave on the marked last word or on the write into the top word.
                    if (load_last || (&wptr_q)) begin
                        state_d = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                if (load_start) begin
                    state_d = ST_LOAD;
                    wptr_d  = '0;
                    count_d = '0;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Fetch qualification: only RUN serves fetches; out-of-range fetches latch addr_err.
    always_comb begin
        inst_valid_d = 1'b0;
        addr_err_d   = addr_err_q;
        if ((state_q == ST_RUN) && (ce == CHIP_ENABLE)) begin
            if (addr_in_range) begin
                inst_valid_d = 1'b1;
            end else begin
                addr_err_d = 1'b1;
            end
        end
    end

    // State registers; store contents are deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_RUN;
            wptr_q       <= '0;
            count_q      <= '0;
            inst_valid_q <= 1'b0;
            addr_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            wptr_q       <= wptr_d;
            count_q      <= count_d;
            inst_valid_q <= inst_valid_d;
            addr_err_q   <= addr_err_d;
        end
    end

    // The array read register always holds mem[addr of last cycle]; the registered
    // valid flag selects it or the NOP word.
    assign inst       = inst_valid_q ? mem_rdata : NOP_WORD;
    assign inst_valid = inst_valid_q;
    assign addr_err   = addr_err_q;
    assign stallreq   = (state_q != ST_RUN);
    assign load_busy  = (state_q != ST_RUN);
    assign load_count = count_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_inst_mem_responder.sv
// Directed bench for inst_mem_responder: loads, fetches, range errors, restarts, full store.
module tb_inst_mem_responder;

    logic        clk;
    logic        rst;
    logic        ce;
    logic [31:0] addr;
    logic [31:0] inst;
    logic        inst_valid;
    logic        addr_err;
    logic        stallreq;
    logic        load_start;
    logic        load_valid;
    logic [31:0] load_data;
    logic        load_last;
    logic        load_busy;
    logic [10:0] load_count;
    logic [1:0]  dbg_state;

    int tests;
    int errors;

    inst_mem_responder dut (
        .clk        (clk),
        .rst        (rst),
        .ce         (ce),
        .addr       (addr),
        .inst       (inst),
        .inst_valid (inst_valid),
        .addr_err   (addr_err),
        .stallreq   (stallreq),
        .load_start (load_start),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_last  (load_last),
        .load_busy  (load_busy),
        .load_count (load_count),
        .dbg_state  (dbg_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and settle; inputs set after this apply at the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ce         = 1'b0;
        addr       = 32'd0;
        load_start = 1'b0;
        load_valid = 1'b0;
        load_data  = 32'd0;
        load_last  = 1'b0;
    endtask

    // Driver: offer one load word for the next edge.
    task automatic drive_word(input logic [31:0] d, input logic last);
        load_start = 1'b0;
        load_valid = 1'b1;
        load_data  = d;
        load_last  = last;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        tick(); tick(); tick();
        tests++; if (inst !== 32'd0) begin $display("FAIL reset_inst got=%h exp=%h", inst, 32'd0); errors++; end
        tests++; if (inst_valid !== 1'b0) begin $display("FAIL reset_valid got=%b exp=0", inst_valid); errors++; end
        tests++; if (stallreq !== 1'b0) begin $display("FAIL reset_stallreq got=%b exp=0", stallreq); errors++; end
        tests++; if (addr_err !== 1'b0) begin $display("FAIL reset_addr_err got=%b exp=0", addr_err); errors++; end
        tests++; if (load_busy !== 1'b0) begin $display("FAIL reset_busy got=%b exp=0", load_busy); errors++; end
        tests++; if (load_count !== 11'd0) begin $display("FAIL reset_count got=%0d exp=0", load_count); errors++; end
        tests++; if (dbg_state !== 2'd0) begin $display("FAIL reset_state got=%0d exp=0", dbg_state); errors++; end
        rst = 1'b0;
        tick();
        tests++; if ({inst, inst_valid, stallreq, addr_err} !== 35'd0) begin
            $display("FAIL post_reset_idle got inst=%h v=%b s=%b e=%b exp all 0", inst, inst_valid, stallreq, addr_err); errors++; end
    endtask

    task automatic test_load_fetch();
        logic [31:0] w [4];
        w[0] = 32'h11; w[1] = 32'h22; w[2] = 32'h33; w[3] = 32'h44;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        tests++; if (stallreq !== 1'b1 || load_busy !== 1'b1 || dbg_state !== 2'd1) begin
            $display("FAIL load_enter got s=%b b=%b st=%0d exp 1 1 1", stallreq, load_busy, dbg_state); errors++; end
        for (int i = 0; i < 4; i++) begin
            drive_word(w[i], i == 3);
            tick();
            tests++; if (load_count !== 11'(i + 1) || stallreq !== 1'b1) begin
                $display("FAIL load_word%0d got cnt=%0d s=%b exp cnt=%0d s=1", i, load_count, stallreq, i + 1); errors++; end
        end
        idle_inputs();
        tests++; if (dbg_state !== 2'd2) begin $display("FAIL load_flush_state got=%0d exp=2", dbg_state); errors++; end
        tick();
        tests++; if (stallreq !== 1'b0 || load_busy !== 1'b0 || dbg_state !== 2'd0 || load_count !== 11'd4) begin
            $display("FAIL load_done got s=%b b=%b st=%0d cnt=%0d exp 0 0 0 4", stallreq, load_busy, dbg_state, load_count); errors++; end
        for (int i = 0; i < 4; i++) begin
            ce = 1'b1; addr = 32'(i);
            tick();
            tests++; if (inst !== w[i] || inst_valid !== 1'b1) begin
                $display("FAIL fetch%0d got=%h v=%b exp=%h v=1", i, inst, inst_valid, w[i]); errors++; end
        end
        idle_inputs();
    endtask

    task automatic test_out_of_range();
        ce = 1'b1; addr = 32'd1024;
        tick();
        tests++; if (inst !== 32'd0 || inst_valid !== 1'b0 || addr_err !== 1'b1) begin
            $display("FAIL oor_1024 got=%h v=%b e=%b exp=0 v=0 e=1", inst, inst_valid, addr_err); errors++; end
        addr = 32'h0001_0002;  // would alias word 2 if upper bits were dropped
        tick();
        tests++; if (inst !== 32'd0 || inst_valid !== 1'b0) begin
            $display("FAIL oor_high got=%h v=%b exp=0 v=0", inst, inst_valid); errors++; end
        addr = 32'd1023;
        tick();
        tests++; if (inst_valid !== 1'b1) begin $display("FAIL top_word_valid got=%b exp=1", inst_valid); errors++; end
        addr = 32'd0;
        tick();
        tests++; if (inst !== 32'h11 || inst_valid !== 1'b1 || addr_err !== 1'b1) begin
            $display("FAIL oor_sticky got=%h v=%b e=%b exp=11 v=1 e=1", inst, inst_valid, addr_err); errors++; end
        idle_inputs();
    endtask

    task automatic test_stall_hold();
        ce = 1'b1; addr = 32'd2;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++; if (inst !== 32'h33 || inst_valid !== 1'b1) begin
                $display("FAIL hold%0d got=%h v=%b exp=33 v=1", i, inst, inst_valid); errors++; end
        end
        ce = 1'b0;
        tick();
        tests++; if (inst !== 32'd0 || inst_valid !== 1'b0) begin
            $display("FAIL ce_off got=%h v=%b exp=0 v=0", inst, inst_valid); errors++; end
    endtask

    task automatic test_gapped_load();
        logic [31:0] w [4];
        w[0] = 32'hA0; w[1] = 32'hA1; w[2] = 32'hA2; w[3] = 32'hA3;
        load_start = 1'b1;
        tick();
        // fetch requested during the load must be refused
        ce = 1'b1; addr = 32'd0;
        drive_word(w[0], 1'b0); tick();
        tests++; if (inst_valid !== 1'b0 || inst !== 32'd0) begin
            $display("FAIL fetch_in_load got=%h v=%b exp=0 v=0", inst, inst_valid); errors++; end
        ce = 1'b0;
        drive_word(w[1], 1'b0); tick();
        load_valid = 1'b0; load_data = 32'hDEAD_BEEF;
        tick(); tick();
        tests++; if (load_count !== 11'd2 || dbg_state !== 2'd1) begin
            $display("FAIL gap_count got cnt=%0d st=%0d exp cnt=2 st=1", load_count, dbg_state); errors++; end
        drive_word(w[2], 1'b0); tick();
        drive_word(w[3], 1'b1); tick();
        idle_inputs();
        tick();
        tests++; if (load_count !== 11'd4 || stallreq !== 1'b0) begin
            $display("FAIL gap_done got cnt=%0d s=%b exp cnt=4 s=0", load_count, stallreq); errors++; end
        for (int i = 0; i < 4; i++) begin
            ce = 1'b1; addr = 32'(i);
            tick();
            tests++; if (inst !== w[i]) begin $display("FAIL gap_fetch%0d got=%h exp=%h", i, inst, w[i]); errors++; end
        end
        idle_inputs();
    endtask

    task automatic test_restart_and_reset();
        load_start = 1'b1; tick();
        drive_word(32'hB0, 1'b0); tick();
        drive_word(32'hB1, 1'b0); tick();
        tests++; if (load_count !== 11'd2) begin $display("FAIL pre_restart_count got=%0d exp=2", load_count); errors++; end
        load_valid = 1'b0; load_start = 1'b1;
        tick();
        load_start = 1'b0;
        tests++; if (load_count !== 11'd0 || dbg_state !== 2'd1) begin
            $display("FAIL restart got cnt=%0d st=%0d exp cnt=0 st=1", load_count, dbg_state); errors++; end
        drive_word(32'hC0, 1'b1); tick();
        idle_inputs(); tick();
        ce = 1'b1; addr = 32'd0; tick();
        tests++; if (inst !== 32'hC0) begin $display("FAIL restart_word0 got=%h exp=c0", inst); errors++; end
        addr = 32'd1; tick();
        tests++; if (inst !== 32'hB1) begin $display("FAIL restart_word1 got=%h exp=b1", inst); errors++; end
        addr = 32'd2; tick();
        tests++; if (inst !== 32'hA2) begin $display("FAIL restart_word2 got=%h exp=a2", inst); errors++; end
        idle_inputs();
        // reset in the middle of a load
        ce = 1'b1; addr = 32'd4096; tick();  // sets addr_err so reset clearing is visible
        idle_inputs();
        load_start = 1'b1; tick();
        drive_word(32'hD0, 1'b0); tick();
        idle_inputs(); rst = 1'b1; tick();
        rst = 1'b0;
        tests++; if (dbg_state !== 2'd0 || stallreq !== 1'b0 || load_busy !== 1'b0 || load_count !== 11'd0 || addr_err !== 1'b0) begin
            $display("FAIL rst_mid_load got st=%0d s=%b b=%b cnt=%0d e=%b exp 0 0 0 0 0", dbg_state, stallreq, load_busy, load_count, addr_err); errors++; end
        ce = 1'b1; addr = 32'd0; tick();
        tests++; if (inst !== 32'hD0 || inst_valid !== 1'b1) begin
            $display("FAIL rst_keeps_mem got=%h v=%b exp=d0 v=1", inst, inst_valid); errors++; end
        idle_inputs();
    endtask

    task automatic test_full_load();
        load_start = 1'b1; tick();
        for (int i = 0; i < 1024; i++) begin
            drive_word(32'h100 + 32'(i), 1'b0);
            tick();
        end
        tests++; if (dbg_state !== 2'd2 || load_count !== 11'd1024) begin
            $display("FAIL full_flush got st=%0d cnt=%0d exp st=2 cnt=1024", dbg_state, load_count); errors++; end
        drive_word(32'hFFFF_FFFF, 1'b1);  // extra word after fill is dropped
        tick();
        idle_inputs();
        tests++; if (dbg_state !== 2'd0 || load_count !== 11'd1024) begin
            $display("FAIL full_drop got st=%0d cnt=%0d exp st=0 cnt=1024", dbg_state, load_count); errors++; end
        ce = 1'b1; addr = 32'd1023; tick();
        tests++; if (inst !== 32'h4FF) begin $display("FAIL full_top got=%h exp=4ff", inst); errors++; end
        addr = 32'd0; tick();
        tests++; if (inst !== 32'h100) begin $display("FAIL full_bottom got=%h exp=100", inst); errors++; end
        idle_inputs();
    endtask

    initial begin
        tests  = 0;
        errors = 0;
        rst    = 1'b1;
        idle_inputs();
        test_reset();
        test_load_fetch();
        test_out_of_range();
        test_stall_hold();
        test_gapped_load();
        test_restart_and_reset();
        test_full_load();
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
